// File: rtl/gs_dac_mixer.sv
// General Sound DAC back end: volume-gated first-order sigma-delta modulator per
// channel, plus a stereo mix mode that folds even/odd channels into two bitstreams.
module gs_dac_mixer #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int VW       = 6,
    parameter int VOL_STEP = 31,
    parameter int DBUF     = 1
) (
    input  logic                   clk32,
    input  logic                   rst_n,
    input  logic                   smp_we,
    input  logic [$clog2(NCH)-1:0] smp_ch,
    input  logic [DW-1:0]          smp_d,
    input  logic                   vol_we,
    input  logic [$clog2(NCH)-1:0] vol_ch,
    input  logic [VW:0]            vol_d,
    input  logic                   load,
    input  logic                   mode,
    output logic [NCH-1:0]         dac_out,
    output logic                   mix_l,
    output logic                   mix_r
);

    localparam int              SW       = $clog2(NCH / 2);
    localparam int              MW       = DW + SW;
    localparam logic [VW:0]     VOL_FULL = {1'b1, {VW{1'b0}}};
    localparam logic [VW-1:0]   VOL_INC  = VW'(VOL_STEP);

    logic [DW-1:0] r_shadow [NCH];
    logic [DW-1:0] r_active [NCH];
    logic [VW:0]   r_vol    [NCH];
    logic [DW:0]   r_acc    [NCH];
    logic [VW-1:0] r_vol_cnt;
    logic [NCH-1:0] r_vol_en;
    logic          r_mode_q;
    logic [MW:0]   r_mix_l;
    logic [MW:0]   r_mix_r;

    logic [MW-1:0] w_sum_l;
    logic [MW-1:0] w_sum_r;
    logic          w_smp_ok;
    logic          w_vol_ok;

    // Channel indices beyond NCH exist only when NCH is not a power of two.
    assign w_smp_ok = (32'(smp_ch) < 32'(NCH));
    assign w_vol_ok = (32'(vol_ch) < 32'(NCH));

    // NOTE: the sample and volume arrays are a handful of flops, so they take the
    // async reset like the rest of the state; nothing here maps to a RAM macro.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking, so a load coinciding with a write copies the old
            // shadow value and the new sample waits for the following load.
            if (DBUF == 0 || load) begin
                for (int i = 0; i < NCH; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (smp_we && w_smp_ok) begin
                r_shadow[smp_ch] <= smp_d;
            end
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_vol[i] <= '0;
            end
            r_vol_cnt <= '0;
            r_vol_en  <= '0;
        end else begin
            if (vol_we && w_vol_ok) begin
                r_vol[vol_ch] <= (vol_d > VOL_FULL) ? VOL_FULL : vol_d;
            end
            // Odd step visits every count once per 2^VW cycles, spreading the gate.
            r_vol_cnt <= r_vol_cnt + VOL_INC;
            for (int i = 0; i < NCH; i++) begin
                r_vol_en[i] <= ({1'b0, r_vol_cnt} < r_vol[i]);
            end
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (r_vol_en[i]) begin
                    r_acc[i] <= {1'b0, r_acc[i][DW-1:0]} + {1'b0, r_active[i]};
                end else begin
                    r_acc[i][DW] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns the sums and no latch forms.
        w_sum_l = '0;
        w_sum_r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_vol_en[i]) begin
                if (i % 2 == 0) begin
                    w_sum_l = w_sum_l + MW'(r_active[i]);
                end else begin
                    w_sum_r = w_sum_r + MW'(r_active[i]);
                end
            end
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= 1'b0;
            r_mix_l  <= '0;
            r_mix_r  <= '0;
        end else begin
            r_mode_q <= mode;
            if (mode && !r_mode_q) begin
                r_mix_l <= '0;
                r_mix_r <= '0;
            end else if (mode) begin
                r_mix_l <= {1'b0, r_mix_l[MW-1:0]} + {1'b0, w_sum_l};
                r_mix_r <= {1'b0, r_mix_r[MW-1:0]} + {1'b0, w_sum_r};
            end else begin
                r_mix_l[MW] <= 1'b0;
                r_mix_r[MW] <= 1'b0;
            end
        end
    end

    always_comb begin
        dac_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!mode) begin
                dac_out[i] = r_acc[i][DW];
            end
        end
    end

    assign mix_l = r_mix_l[MW];
    assign mix_r = r_mix_r[MW];

endmodule
